// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared encodings for the multicycle MIPS control unit.
// ALUOp codes are the same ones the ALU decodes.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_REXE, S_RWB, S_IEXE, S_IWB, S_BRANCH, S_JUMP
    } state_t;

    typedef enum logic [3:0] {
        C_ILL, C_LW, C_SW, C_R, C_ORI, C_ADDIU, C_BEQ, C_BNE, C_J
    } cls_t;

    localparam logic [2:0] ALU_OR  = 3'b000;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b110;

    localparam logic [5:0] OP_R     = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] F_ADDU = 6'b100001;
    localparam logic [5:0] F_SUBU = 6'b100011;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_SLT  = 6'b101010;

endpackage

// File: rtl/mc_decode.sv
// mc_decode: combinational Op/Funct to instruction class and R-type ALUOp.
// Unsupported Op or R-type Funct maps to C_ILL.
module mc_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] i_op,
    input  logic [5:0] i_funct,
    output cls_t       o_cls,
    output logic [2:0] o_aluop
);

    logic w_rok;

    always_comb begin
        o_aluop = ALU_ADD;
        w_rok   = 1'b1;
        case (i_funct)
            F_ADDU:  o_aluop = ALU_ADD;
            F_SUBU:  o_aluop = ALU_SUB;
            F_OR:    o_aluop = ALU_OR;
            F_SLT:   o_aluop = ALU_SLT;
            default: w_rok   = 1'b0;
        endcase
        o_cls = C_ILL;
        case (i_op)
            OP_R:     o_cls = w_rok ? C_R : C_ILL;
            OP_LW:    o_cls = C_LW;
            OP_SW:    o_cls = C_SW;
            OP_BEQ:   o_cls = C_BEQ;
            OP_BNE:   o_cls = C_BNE;
            OP_ORI:   o_cls = C_ORI;
            OP_ADDIU: o_cls = C_ADDIU;
            OP_J:     o_cls = C_J;
            default:  o_cls = C_ILL;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle MIPS control FSM driving datapath selects, enables and ALUOp.
// Class and R-type ALUOp are latched in DECODE so later states never re-read IR.
module mc_ctrl
    import mc_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  Op,
    input  logic [5:0]  Funct,
    input  logic        Zero,
    output logic        PCWrite,
    output logic        IorD,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic        RegDst,
    output logic        MemtoReg,
    output logic        ExtOp,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  PCSource,
    output logic [2:0]  ALUOp,
    output logic        Illegal,
    output logic [31:0] InstCnt
);

    state_t     r_state, w_next;
    cls_t       r_cls, w_cls;
    logic [2:0] r_raluop, w_raluop;
    logic [31:0] r_cnt;
    logic       w_pcw, w_mw, w_irw, w_rw, w_ill, w_done;

    mc_decode u_dec (.i_op(Op), .i_funct(Funct), .o_cls(w_cls), .o_aluop(w_raluop));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_FETCH;
            r_cls    <= C_ILL;
            r_raluop <= ALU_ADD;
            r_cnt    <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_cls    <= w_cls;
                r_raluop <= w_raluop;
            end
            if (w_done) r_cnt <= r_cnt + 32'd1;
        end
    end

    always_comb begin
        w_next   = S_FETCH;
        w_pcw    = 1'b0;
        IorD     = 1'b0;
        w_mw     = 1'b0;
        w_irw    = 1'b0;
        w_rw     = 1'b0;
        RegDst   = 1'b0;
        MemtoReg = 1'b0;
        ExtOp    = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 2'b00;
        PCSource = 2'b00;
        ALUOp    = ALU_OR;
        w_ill    = 1'b0;
        w_done   = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_irw = 1'b1; w_pcw = 1'b1; ALUSrcB = 2'b01; ALUOp = ALU_ADD;
                w_next = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11; ExtOp = 1'b1; ALUOp = ALU_ADD;
                w_ill = (w_cls == C_ILL);
                case (w_cls)
                    C_LW, C_SW:     w_next = S_MEMADR;
                    C_R:            w_next = S_REXE;
                    C_ORI, C_ADDIU: w_next = S_IEXE;
                    C_BEQ, C_BNE:   w_next = S_BRANCH;
                    C_J:            w_next = S_JUMP;
                    default:        w_next = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1; ALUSrcB = 2'b10; ExtOp = 1'b1; ALUOp = ALU_ADD;
                w_next = (r_cls == C_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                IorD = 1'b1; w_next = S_MEMWB;
            end
            S_MEMWB: begin
                w_rw = 1'b1; MemtoReg = 1'b1; w_done = 1'b1;
            end
            S_MEMWR: begin
                IorD = 1'b1; w_mw = 1'b1; w_done = 1'b1;
            end
            S_REXE: begin
                ALUSrcA = 1'b1; ALUOp = r_raluop; w_next = S_RWB;
            end
            S_RWB: begin
                w_rw = 1'b1; RegDst = 1'b1; w_done = 1'b1;
            end
            S_IEXE: begin
                ALUSrcA = 1'b1; ALUSrcB = 2'b10;
                ExtOp = (r_cls != C_ORI);
                ALUOp = (r_cls == C_ORI) ? ALU_OR : ALU_ADD;
                w_next = S_IWB;
            end
            S_IWB: begin
                w_rw = 1'b1; w_done = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA = 1'b1; ALUOp = ALU_SUB; PCSource = 2'b01;
                w_pcw = (r_cls == C_BEQ) ? Zero : ~Zero;
                w_done = 1'b1;
            end
            S_JUMP: begin
                PCSource = 2'b10; w_pcw = 1'b1; w_done = 1'b1;
            end
            default: w_next = S_FETCH;
        endcase
    end

    // Enables are gated by rst_n directly so they are low for the whole reset.
    assign PCWrite  = rst_n & w_pcw;
    assign MemWrite = rst_n & w_mw;
    assign IRWrite  = rst_n & w_irw;
    assign RegWrite = rst_n & w_rw;
    assign Illegal  = rst_n & w_ill;
    assign InstCnt  = r_cnt;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: randomized scoreboard bench for mc_ctrl.
// Each instruction pushes its expected per-cycle control vectors; a negedge monitor pops and compares.
module tb_mc_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  Op = 6'd0, Funct = 6'd0;
    logic        Zero = 1'b0;
    logic        PCWrite, IorD, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg, ExtOp, ALUSrcA, Illegal;
    logic [1:0]  ALUSrcB, PCSource;
    logic [2:0]  ALUOp;
    logic [31:0] InstCnt;

    mc_ctrl dut (
        .clk(clk), .rst_n(rst_n), .Op(Op), .Funct(Funct), .Zero(Zero),
        .PCWrite(PCWrite), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .ExtOp(ExtOp),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource), .ALUOp(ALUOp),
        .Illegal(Illegal), .InstCnt(InstCnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [16:0] v;
        logic [31:0] c;
        string       n;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] mcnt = 0;

    wire [16:0] act = {PCWrite, IorD, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg, ExtOp,
                       ALUSrcA, ALUSrcB, PCSource, ALUOp, Illegal};

    // Vector order: pcw iord mw irw rw rd m2r ext srca srcb pcs aluop ill
    function automatic logic [16:0] ev(input logic pcw, iord, mw, irw, rw, rd, m2r, ext, sa,
                                       input logic [1:0] sb, ps, input logic [2:0] ao, input logic il);
        return {pcw, iord, mw, irw, rw, rd, m2r, ext, sa, sb, ps, ao, il};
    endfunction

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %h want %h", n, a, e);
        end
    endtask

    task automatic push(input logic [16:0] v, input string n);
        exp_t x;
        x.v = v; x.c = mcnt; x.n = n;
        q.push_back(x);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t x;
            x = q.pop_front();
            chk({x.n, "_ctl"}, {15'd0, act}, {15'd0, x.v});
            chk({x.n, "_cnt"}, InstCnt, x.c);
        end
    end

    // kind: 0 addu 1 subu 2 or 3 slt 4 lw 5 sw 6 beq 7 bne 8 ori 9 addiu 10 j 11 bad op 12 bad funct
    function automatic bit op_known(input logic [5:0] o);
        return o inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b001101, 6'b001001, 6'b000010};
    endfunction

    function automatic bit fn_known(input logic [5:0] f);
        return f inside {6'b100001, 6'b100011, 6'b100101, 6'b101010};
    endfunction

    task automatic set_inst(input int k);
        logic [5:0] fr [4];
        logic [5:0] t;
        fr[0] = 6'b100001; fr[1] = 6'b100011; fr[2] = 6'b100101; fr[3] = 6'b101010;
        Funct = 6'($urandom);
        case (k)
            0, 1, 2, 3: begin Op = 6'b000000; Funct = fr[k]; end
            4:  Op = 6'b100011;
            5:  Op = 6'b101011;
            6:  Op = 6'b000100;
            7:  Op = 6'b000101;
            8:  Op = 6'b001101;
            9:  Op = 6'b001001;
            10: Op = 6'b000010;
            11: begin
                t = 6'($urandom);
                while (op_known(t)) t = 6'($urandom);
                Op = t;
            end
            default: begin
                t = 6'($urandom);
                while (fn_known(t)) t = 6'($urandom);
                Op = 6'b000000; Funct = t;
            end
        endcase
    endtask

    // Called at posedge+1 with the DUT in FETCH; returns the cycle count of the instruction.
    task automatic model(input int k, input logic z, output int n);
        logic [2:0] ra [4];
        ra[0] = 3'b010; ra[1] = 3'b011; ra[2] = 3'b000; ra[3] = 3'b110;
        push(ev(1,0,0,1,0,0,0,0,0,2'b01,2'b00,3'b010,0), "fetch");
        push(ev(0,0,0,0,0,0,0,1,0,2'b11,2'b00,3'b010,(k >= 11)), "decode");
        n = 2;
        if (k <= 3) begin
            push(ev(0,0,0,0,0,0,0,0,1,2'b00,2'b00,ra[k],0), "rexe");
            push(ev(0,0,0,0,1,1,0,0,0,2'b00,2'b00,3'b000,0), "rwb");
            n = 4;
        end else if (k == 4 || k == 5) begin
            push(ev(0,0,0,0,0,0,0,1,1,2'b10,2'b00,3'b010,0), "memadr");
            if (k == 4) begin
                push(ev(0,1,0,0,0,0,0,0,0,2'b00,2'b00,3'b000,0), "memrd");
                push(ev(0,0,0,0,1,0,1,0,0,2'b00,2'b00,3'b000,0), "memwb");
                n = 5;
            end else begin
                push(ev(0,1,1,0,0,0,0,0,0,2'b00,2'b00,3'b000,0), "memwr");
                n = 4;
            end
        end else if (k == 6 || k == 7) begin
            push(ev((k == 6) ? z : ~z,0,0,0,0,0,0,0,1,2'b00,2'b01,3'b011,0), "branch");
            n = 3;
        end else if (k == 8 || k == 9) begin
            push(ev(0,0,0,0,0,0,0,(k == 9),1,2'b10,2'b00,(k == 9) ? 3'b010 : 3'b000,0), "iexe");
            push(ev(0,0,0,0,1,0,0,0,0,2'b00,2'b00,3'b000,0), "iwb");
            n = 4;
        end else if (k == 10) begin
            push(ev(1,0,0,0,0,0,0,0,0,2'b00,2'b10,3'b000,0), "jump");
            n = 3;
        end
        if (k < 11) mcnt = mcnt + 32'd1;
    endtask

    task automatic run(input int k, input logic z);
        int n;
        set_inst(k);
        Zero = z;
        model(k, z, n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic reset_checks(input string n);
        chk({n, "_en"}, {28'd0, PCWrite, IRWrite, MemWrite, RegWrite}, 32'd0);
        chk({n, "_ill"}, {31'd0, Illegal}, 32'd0);
        chk({n, "_cnt"}, InstCnt, 32'd0);
        chk({n, "_sel"}, {27'd0, ALUSrcB, ALUOp}, {27'd0, 2'b01, 3'b010});
    endtask

    initial begin
        int n;
        repeat (3) begin
            @(negedge clk);
            reset_checks("rst");
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        run(3, 1'b0);
        run(4, 1'b0);
        run(5, 1'b1);
        run(6, 1'b1);
        run(7, 1'b1);
        run(8, 1'b0);
        Op = 6'b111111;
        Zero = 1'b0;
        model(11, 1'b0, n);
        repeat (n) @(posedge clk);
        #1;
        run(10, 1'b0);
        // Abandon a lw in MEMRD: only the first three cycles are expected normally.
        set_inst(4);
        model(4, 1'b0, n);
        void'(q.pop_back());
        void'(q.pop_back());
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        mcnt = 0;
        #1;
        reset_checks("midrst");
        repeat (2) begin
            @(negedge clk);
            reset_checks("midrst_hold");
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        run(0, 1'b0);
        for (int i = 0; i < 80; i++) run($urandom_range(0, 12), 1'($urandom));
        @(negedge clk);
        chk("queue_empty", q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
